// File: rtl/cnn_load_sequencer.sv
// cnn_load_sequencer
// Front-end controller for the binary CNN classifier. Streams image rows,
// 5x5 binary kernels and offsets into the datapath memories with
// auto-incrementing addresses, then steps the five layer stages
// (conv1, pool1, conv2, pool2, fc) through start/done handshakes under a
// per-stage watchdog and holds the final class.
module cnn_load_sequencer #(
    parameter int IMG_ROWS    = 28,
    parameter int IMG_W       = 28,
    parameter int NUM_KERNELS = 1170,
    parameter int KW          = 25,
    parameter int NUM_OFFSETS = 78,
    parameter int BW          = 8,
    parameter int CLASS_W     = 4,
    parameter int TIMEOUT     = 4096,
    localparam int IMG_AW     = $clog2(IMG_ROWS),
    localparam int KER_AW     = $clog2(NUM_KERNELS),
    localparam int OFF_AW     = $clog2(NUM_OFFSETS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_type,
    input  logic [31:0]        cfg_data,
    input  logic               start,
    input  logic               abort,
    output logic               img_we,
    output logic [IMG_AW-1:0]  img_addr,
    output logic [IMG_W-1:0]   img_wdata,
    output logic               ker_we,
    output logic [KER_AW-1:0]  ker_addr,
    output logic [KW-1:0]      ker_wdata,
    output logic               off_we,
    output logic [OFF_AW-1:0]  off_addr,
    output logic [BW-1:0]      off_wdata,
    output logic [4:0]         stage_start,
    input  logic [4:0]         stage_done,
    input  logic [CLASS_W-1:0] fc_class,
    output logic               busy,
    output logic               done,
    output logic [CLASS_W-1:0] class_out,
    output logic               class_valid,
    output logic               err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_ROWS - 1);
    localparam logic [KER_AW-1:0] KER_LAST = KER_AW'(NUM_KERNELS - 1);
    localparam logic [OFF_AW-1:0] OFF_LAST = OFF_AW'(NUM_OFFSETS - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [2:0]        FC_STAGE = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IMG_AW-1:0]   img_cnt_q, img_cnt_d;
    logic [KER_AW-1:0]   ker_cnt_q, ker_cnt_d;
    logic [OFF_AW-1:0]   off_cnt_q, off_cnt_d;
    logic                img_ld_q, img_ld_d;
    logic                ker_ld_q, ker_ld_d;
    logic                off_ld_q, off_ld_d;
    logic                img_we_q, img_we_d;
    logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
    logic [IMG_W-1:0]    img_wdata_q, img_wdata_d;
    logic                ker_we_q, ker_we_d;
    logic [KER_AW-1:0]   ker_addr_q, ker_addr_d;
    logic [KW-1:0]       ker_wdata_q, ker_wdata_d;
    logic                off_we_q, off_we_d;
    logic [OFF_AW-1:0]   off_addr_q, off_addr_d;
    logic [BW-1:0]       off_wdata_q, off_wdata_d;
    logic [2:0]          stage_q, stage_d;
    logic [4:0]          stage_start_q, stage_start_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                done_q, done_d;
    logic [CLASS_W-1:0]  class_q, class_d;
    logic                class_valid_q, class_valid_d;
    logic                err_q, err_d;

    logic       idle_like;
    logic       beat_acc;
    logic       start_acc;
    logic [4:0] exp_done;
    logic       done_hit;
    logic       done_stray;

    // Payload bits above the widest memory word carry nothing.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data[31:IMG_W];

    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    // Start has priority over a config beat in the same cycle; the beat stalls.
    assign cfg_ready  = rst_n & idle_like & ~start;
    assign beat_acc   = cfg_valid & cfg_ready;
    assign start_acc  = start & idle_like & img_ld_q & ker_ld_q & off_ld_q;
    assign exp_done   = 5'b00001 << stage_q;
    assign done_hit   = |(stage_done & exp_done);
    assign done_stray = |(stage_done & ~exp_done);

    // Next-state: config write path, loaded flags, stage sequencing, watchdog.
    always_comb begin
        state_d       = state_q;
        img_cnt_d     = img_cnt_q;
        ker_cnt_d     = ker_cnt_q;
        off_cnt_d     = off_cnt_q;
        img_ld_d      = img_ld_q;
        ker_ld_d      = ker_ld_q;
        off_ld_d      = off_ld_q;
        img_we_d      = 1'b0;
        img_addr_d    = img_addr_q;
        img_wdata_d   = img_wdata_q;
        ker_we_d      = 1'b0;
        ker_addr_d    = ker_addr_q;
        ker_wdata_d   = ker_wdata_q;
        off_we_d      = 1'b0;
        off_addr_d    = off_addr_q;
        off_wdata_d   = off_wdata_q;
        stage_d       = stage_q;
        stage_start_d = 5'b0;
        wdog_d        = wdog_q;
        done_d        = 1'b0;
        class_d       = class_q;
        class_valid_d = class_valid_q;
        err_d         = err_q;

        if (beat_acc) begin
            unique case (cfg_type)
                2'd0: begin
                    img_we_d    = 1'b1;
                    img_addr_d  = img_cnt_q;
                    img_wdata_d = cfg_data[IMG_W-1:0];
                    img_cnt_d   = (img_cnt_q == IMG_LAST) ? '0 : img_cnt_q + 1'b1;
                    if (img_cnt_q == IMG_LAST)  img_ld_d = 1'b1;
                    else if (img_cnt_q == '0)   img_ld_d = 1'b0;
                end
                2'd1: begin
                    ker_we_d    = 1'b1;
                    ker_addr_d  = ker_cnt_q;
                    ker_wdata_d = cfg_data[KW-1:0];
                    ker_cnt_d   = (ker_cnt_q == KER_LAST) ? '0 : ker_cnt_q + 1'b1;
                    if (ker_cnt_q == KER_LAST)  ker_ld_d = 1'b1;
                    else if (ker_cnt_q == '0)   ker_ld_d = 1'b0;
                end
                2'd2: begin
                    off_we_d    = 1'b1;
                    off_addr_d  = off_cnt_q;
                    off_wdata_d = cfg_data[BW-1:0];
                    off_cnt_d   = (off_cnt_q == OFF_LAST) ? '0 : off_cnt_q + 1'b1;
                    if (off_cnt_q == OFF_LAST)  off_ld_d = 1'b1;
                    else if (off_cnt_q == '0)   off_ld_d = 1'b0;
                end
                default: err_d = 1'b1;  // reserved type: consumed, nothing written
            endcase
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d       = S_RUN;
                    stage_d       = '0;
                    stage_start_d = 5'b00001;
                    wdog_d        = '0;
                    class_valid_d = 1'b0;
                end else if (start) begin
                    err_d = 1'b1;  // memories not fully loaded
                end
            end
            S_RUN: begin
                if (start) err_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (done_stray) err_d = 1'b1;
                    if (done_hit) begin
                        wdog_d = '0;
                        if (stage_q == FC_STAGE) begin
                            class_d       = fc_class;
                            class_valid_d = 1'b1;
                            done_d        = 1'b1;
                            state_d       = S_DONE;
                        end else begin
                            stage_d       = stage_q + 3'd1;
                            stage_start_d = exp_done << 1;
                        end
                    end else if (wdog_q == WD_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; async reset returns everything to idle/unloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            img_cnt_q     <= '0;
            ker_cnt_q     <= '0;
            off_cnt_q     <= '0;
            img_ld_q      <= 1'b0;
            ker_ld_q      <= 1'b0;
            off_ld_q      <= 1'b0;
            img_we_q      <= 1'b0;
            img_addr_q    <= '0;
            img_wdata_q   <= '0;
            ker_we_q      <= 1'b0;
            ker_addr_q    <= '0;
            ker_wdata_q   <= '0;
            off_we_q      <= 1'b0;
            off_addr_q    <= '0;
            off_wdata_q   <= '0;
            stage_q       <= '0;
            stage_start_q <= '0;
            wdog_q        <= '0;
            done_q        <= 1'b0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            img_cnt_q     <= img_cnt_d;
            ker_cnt_q     <= ker_cnt_d;
            off_cnt_q     <= off_cnt_d;
            img_ld_q      <= img_ld_d;
            ker_ld_q      <= ker_ld_d;
            off_ld_q      <= off_ld_d;
            img_we_q      <= img_we_d;
            img_addr_q    <= img_addr_d;
            img_wdata_q   <= img_wdata_d;
            ker_we_q      <= ker_we_d;
            ker_addr_q    <= ker_addr_d;
            ker_wdata_q   <= ker_wdata_d;
            off_we_q      <= off_we_d;
            off_addr_q    <= off_addr_d;
            off_wdata_q   <= off_wdata_d;
            stage_q       <= stage_d;
            stage_start_q <= stage_start_d;
            wdog_q        <= wdog_d;
            done_q        <= done_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            err_q         <= err_d;
        end
    end

    assign img_we      = img_we_q;
    assign img_addr    = img_addr_q;
    assign img_wdata   = img_wdata_q;
    assign ker_we      = ker_we_q;
    assign ker_addr    = ker_addr_q;
    assign ker_wdata   = ker_wdata_q;
    assign off_we      = off_we_q;
    assign off_addr    = off_addr_q;
    assign off_wdata   = off_wdata_q;
    assign stage_start = stage_start_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign class_out   = class_q;
    assign class_valid = class_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Directed bench for cnn_load_sequencer: loading, stage handshakes, watchdog,
// abort, start/beat collision, partial reload and mid-run reset.
module tb_cnn_load_sequencer;

    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_type = 2'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        img_we;
    logic [4:0]  img_addr;
    logic [27:0] img_wdata;
    logic        ker_we;
    logic [10:0] ker_addr;
    logic [24:0] ker_wdata;
    logic        off_we;
    logic [6:0]  off_addr;
    logic [7:0]  off_wdata;
    logic [4:0]  stage_start;
    logic [4:0]  stage_done = 5'd0;
    logic [3:0]  fc_class = 4'd0;
    logic        busy;
    logic        done;
    logic [3:0]  class_out;
    logic        class_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    cnn_load_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type), .cfg_data(cfg_data),
        .start(start), .abort(abort),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .ker_we(ker_we), .ker_addr(ker_addr), .ker_wdata(ker_wdata),
        .off_we(off_we), .off_addr(off_addr), .off_wdata(off_wdata),
        .stage_start(stage_start), .stage_done(stage_done), .fc_class(fc_class),
        .busy(busy), .done(done), .class_out(class_out), .class_valid(class_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pat(input int i, input logic [1:0] t);
        return 32'hA5C3_0000 ^ (i * 32'h0001_0F1D) ^ {30'd0, t};
    endfunction

    // Streams n beats of type t, indices first..first+n-1, one per cycle,
    // checking each registered write one cycle after acceptance.
    task automatic load_type(input logic [1:0] t, input int first, input int n);
        int N;
        N = (t == 2'd0) ? 28 : (t == 2'd1) ? 1170 : 78;
        for (int i = first; i < first + n; i++) begin
            logic [31:0] d;
            int e;
            d = pat(i, t);
            e = i % N;
            cfg_valid = 1'b1; cfg_type = t; cfg_data = d;
            @(negedge clk);
            cfg_valid = 1'b0;
            checks++;
            case (t)
                2'd0: if (img_we !== 1'b1 || img_addr !== e[4:0] || img_wdata !== d[27:0]) begin
                    errors++;
                    $display("FAIL img_write idx %0d: we=%b addr=%0d data=%h want 1 %0d %h",
                             i, img_we, img_addr, img_wdata, e, d[27:0]);
                end
                2'd1: if (ker_we !== 1'b1 || ker_addr !== e[10:0] || ker_wdata !== d[24:0]) begin
                    errors++;
                    $display("FAIL ker_write idx %0d: we=%b addr=%0d data=%h want 1 %0d %h",
                             i, ker_we, ker_addr, ker_wdata, e, d[24:0]);
                end
                default: if (off_we !== 1'b1 || off_addr !== e[6:0] || off_wdata !== d[7:0]) begin
                    errors++;
                    $display("FAIL off_write idx %0d: we=%b addr=%0d data=%h want 1 %0d %h",
                             i, off_we, off_addr, off_wdata, e, d[7:0]);
                end
            endcase
        end
    endtask

    task automatic load_all();
        load_type(2'd0, 0, 28);
        load_type(2'd1, 0, 1170);
        load_type(2'd2, 0, 78);
    endtask

    // Pulses start for one cycle; stage 0 must start the following cycle.
    task automatic start_accept();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (stage_start !== 5'b00001 || busy !== 1'b1 || class_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_accept: stage_start=%b busy=%b class_valid=%b want 00001 1 0",
                     stage_start, busy, class_valid);
        end
    endtask

    // Answers stages 0..4 after 3,10,3,10,5 cycles with fc_class=7.
    task automatic run_stages();
        int dly [5] = '{3, 10, 3, 10, 5};
        for (int s = 0; s < 5; s++) begin
            logic [4:0] nxt;
            for (int k = 0; k < dly[s] - 1; k++) begin
                @(negedge clk);
                checks++;
                if (stage_start !== 5'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stage%0d_wait: stage_start=%b busy=%b want 00000 1", s, stage_start, busy);
                end
            end
            stage_done = 5'b00001 << s;
            fc_class = (s == 4) ? 4'd7 : 4'd0;
            @(negedge clk);
            stage_done = 5'b0;
            fc_class = 4'd0;
            nxt = 5'b00001 << (s + 1);
            checks++;
            if (s < 4) begin
                if (stage_start !== nxt || (img_we | ker_we | off_we) !== 1'b0) begin
                    errors++;
                    $display("FAIL stage%0d_next: stage_start=%b we=%b%b%b want %b 000",
                             s, stage_start, img_we, ker_we, off_we, nxt);
                end
            end else begin
                if (done !== 1'b1 || class_out !== 4'd7 || class_valid !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fc_done: done=%b class=%0d valid=%b busy=%b want 1 7 1 0",
                             done, class_out, class_valid, busy);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || class_valid !== 1'b1 || class_out !== 4'd7) begin
            errors++;
            $display("FAIL done_pulse: done=%b valid=%b class=%0d want 0 1 7", done, class_valid, class_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({img_we, ker_we, off_we, stage_start, busy, done, class_out, class_valid, err, cfg_ready} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: %b want all zero",
                     {img_we, ker_we, off_we, stage_start, busy, done, class_out, class_valid, err, cfg_ready});
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (cfg_ready !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: cfg_ready=%b err=%b want 1 0", cfg_ready, err);
        end
    endtask

    task automatic test_load_and_run();
        load_all();
        start_accept();
        run_stages();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL run_err: err=%b want 0", err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = 32'h0000_00C3;
        cfg_valid = 1'b1; cfg_type = 2'd2; cfg_data = d; start = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_ready: cfg_ready=%b want 0", cfg_ready);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (off_we !== 1'b0 || stage_start !== 5'b00001 || class_valid !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_start: off_we=%b stage_start=%b valid=%b ready=%b want 0 00001 0 0",
                     off_we, stage_start, class_valid, cfg_ready);
        end
        run_stages();
        cfg_valid = 1'b0;
        // Held beat accepted on the DONE cycle; offset counter wrapped to 0.
        checks++;
        if (off_we !== 1'b1 || off_addr !== 7'd0 || off_wdata !== d[7:0] || err !== 1'b0) begin
            errors++;
            $display("FAIL held_beat: we=%b addr=%0d data=%h err=%b want 1 0 %h 0",
                     off_we, off_addr, off_wdata, err, d[7:0]);
        end
        load_type(2'd2, 1, 77);
    endtask

    task automatic test_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || class_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: busy=%b err=%b valid=%b want 0 0 1", busy, err, class_valid);
        end
        start_accept();
        tick(1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || stage_start !== 5'b0) begin
            errors++;
            $display("FAIL abort_run: busy=%b stage_start=%b want 0 00000", busy, stage_start);
        end
        stage_done = 5'b00001;
        @(negedge clk);
        stage_done = 5'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || stage_start !== 5'b0 || err !== 1'b0 || class_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: busy=%b stage_start=%b err=%b valid=%b want 0 00000 0 0",
                     busy, stage_start, err, class_valid);
        end
    endtask

    task automatic test_timeout();
        int n;
        start_accept();
        stage_done = 5'b01000;
        @(negedge clk);
        stage_done = 5'b0;
        checks++;
        if (err !== 1'b1 || stage_start !== 5'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_done: err=%b stage_start=%b busy=%b want 1 00000 1", err, stage_start, busy);
        end
        stage_done = 5'b00001;
        @(negedge clk);
        stage_done = 5'b00010;
        @(negedge clk);
        stage_done = 5'b0;
        checks++;
        if (stage_start !== 5'b00100) begin
            errors++;
            $display("FAIL reach_stage2: stage_start=%b want 00100", stage_start);
        end
        n = 0;
        while (busy === 1'b1 && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TIMEOUT + 1) begin
            errors++;
            $display("FAIL watchdog_cycles: got %0d want %0d", n, TIMEOUT + 1);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || class_valid !== 1'b0 || done !== 1'b0 || stage_start !== 5'b0) begin
            errors++;
            $display("FAIL watchdog_state: err=%b busy=%b valid=%b done=%b ss=%b want 1 0 0 0 00000",
                     err, busy, class_valid, done, stage_start);
        end
    endtask

    task automatic test_reset_midrun();
        start_accept();
        tick(2);
        stage_done = 5'b00001;
        @(negedge clk);
        stage_done = 5'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({img_we, ker_we, off_we, stage_start, busy, done, class_valid, err, cfg_ready} !== 12'd0) begin
            errors++;
            $display("FAIL midrun_reset: %b want all zero",
                     {img_we, ker_we, off_we, stage_start, busy, done, class_valid, err, cfg_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (stage_start !== 5'b0 || busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL unloaded_start: stage_start=%b busy=%b err=%b want 00000 0 1", stage_start, busy, err);
        end
    endtask

    task automatic test_partial_image();
        do_reset();
        load_type(2'd0, 0, 27);
        load_type(2'd1, 0, 2340);  // wraps 1169 -> 0 then refills to 1169
        load_type(2'd2, 0, 78);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (stage_start !== 5'b0 || busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL partial_start: stage_start=%b busy=%b err=%b want 00000 0 1", stage_start, busy, err);
        end
        load_type(2'd0, 27, 1);
        start_accept();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reserved_type();
        do_reset();
        cfg_valid = 1'b1; cfg_type = 2'd3; cfg_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reserved_ready: cfg_ready=%b want 1", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ((img_we | ker_we | off_we) !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_beat: we=%b%b%b err=%b want 000 1", img_we, ker_we, off_we, err);
        end
    endtask

    initial begin
        test_reset();
        test_load_and_run();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_midrun();
        test_partial_image();
        test_reserved_type();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
